// File: rtl/game_ctrl_if.sv
// Signal bundle between the game sequencer and the rest of the runner.
// Ports (from the sequencer's point of view, modport slave):
//   fresh        in   VGA vertical sync level; a rising edge marks a frame
//   button_jump  in   debounced jump/start button, active-high level
//   collision    in   dinosaur/obstacle pixel overlap, valid any cycle
//   game_status  out  1 while running
//   game_over    out  1 only after death
//   speed        out  current scroll speed (4 bits)
//   score        out  current run score (16 bits, binary)
//   high_score   out  best score since reset (16 bits)
//   frame_tick   out  one-cycle registered pulse per frame
interface game_ctrl_if;
    logic        fresh;
    logic        button_jump;
    logic        collision;
    logic        game_status;
    logic        game_over;
    logic [3:0]  speed;
    logic [15:0] score;
    logic [15:0] high_score;
    logic        frame_tick;

    modport master (
        output fresh, button_jump, collision,
        input  game_status, game_over, speed, score, high_score, frame_tick
    );

    modport slave (
        input  fresh, button_jump, collision,
        output game_status, game_over, speed, score, high_score, frame_tick
    );
endinterface

// File: rtl/game_ctrl.sv
// Central game sequencer for the dinosaur runner: IDLE/RUN/OVER state
// machine, speed ramp, score in frames survived and session high score.
// Ports:
//   CLK   in  system clock, all logic on its rising edge
//   rst   in  synchronous active-high reset
//   gif   slave side of game_ctrl_if (inputs fresh/button_jump/collision,
//         outputs game_status/game_over/speed/score/high_score/frame_tick)
//
// state  | meaning
// -------+------------------------------------------------------------
// S_IDLE | after reset, waiting for the first press
// S_RUN  | game running, score and speed advance on every clean frame
// S_OVER | dinosaur hit; presses ignored until the holdoff has elapsed
module game_ctrl #(
    parameter int START_SPEED      = 1,
    parameter int MAX_SPEED        = 15,
    parameter int FRAMES_PER_STEP  = 600,
    parameter int FRAMES_PER_POINT = 6,
    parameter int OVER_HOLDOFF     = 30
) (
    input logic        CLK,
    input logic        rst,
    game_ctrl_if.slave gif
);

    localparam int PT_W = (FRAMES_PER_POINT > 1) ? $clog2(FRAMES_PER_POINT) : 1;
    localparam int ST_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam int HO_W = (OVER_HOLDOFF > 0) ? $clog2(OVER_HOLDOFF + 1) : 1;

    // Frame timers count down to zero; zero is the terminal count.
    localparam logic [PT_W-1:0] PT_LOAD = PT_W'(FRAMES_PER_POINT - 1);
    localparam logic [ST_W-1:0] ST_LOAD = ST_W'(FRAMES_PER_STEP - 1);
    localparam logic [HO_W-1:0] HO_LOAD = HO_W'(OVER_HOLDOFF);
    localparam logic [3:0]      SPD_START = 4'(START_SPEED);
    localparam logic [3:0]      SPD_MAX   = 4'(MAX_SPEED);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_OVER} state_t;

    state_t      state, state_d;
    logic        btn_q, fresh_q, coll_q;
    logic        press, tick, start_run, die;
    logic [PT_W-1:0] pt_cnt;
    logic [ST_W-1:0] st_cnt;
    logic [HO_W-1:0] ho_cnt;
    logic [3:0]  speed_q;
    logic [15:0] score_q, high_q;
    logic        ftick_q;
    logic        status_c, over_c;

    assign press = gif.button_jump & ~btn_q;
    assign tick  = gif.fresh & ~fresh_q;

    // ho_cnt == 0 means the holdoff has fully elapsed.
    assign start_run = press & ((state == S_IDLE) | ((state == S_OVER) & (ho_cnt == '0)));
    // A collision in the tick cycle itself still counts for that frame.
    assign die       = (state == S_RUN) & tick & (coll_q | gif.collision);

    always_ff @(posedge CLK) begin
        if (rst) state <= S_IDLE;
        else     state <= state_d;
    end

    always_comb begin
        state_d = state;
        case (state)
            S_IDLE:  if (start_run) state_d = S_RUN;
            S_RUN:   if (die)       state_d = S_OVER;
            S_OVER:  if (start_run) state_d = S_RUN;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        status_c = (state == S_RUN);
        over_c   = (state == S_OVER);
    end

    always_ff @(posedge CLK) begin
        if (rst) begin
            btn_q   <= 1'b0;
            fresh_q <= 1'b0;
            coll_q  <= 1'b0;
            ftick_q <= 1'b0;
            pt_cnt  <= '0;
            st_cnt  <= '0;
            ho_cnt  <= '0;
            speed_q <= SPD_START;
            score_q <= 16'd0;
            high_q  <= 16'd0;
        end else begin
            btn_q   <= gif.button_jump;
            fresh_q <= gif.fresh;
            ftick_q <= tick;

            if (tick | start_run)
                coll_q <= 1'b0;
            else if ((state == S_RUN) & gif.collision)
                coll_q <= 1'b1;

            // Restart has priority, so a tick coinciding with the press is dropped.
            if (start_run) begin
                score_q <= 16'd0;
                speed_q <= SPD_START;
                pt_cnt  <= PT_LOAD;
                st_cnt  <= ST_LOAD;
            end else if (die) begin
                ho_cnt <= HO_LOAD;
                if (score_q > high_q) high_q <= score_q;
            end else if ((state == S_RUN) & tick) begin
                if (pt_cnt == '0) begin
                    pt_cnt <= PT_LOAD;
                    if (score_q != 16'hFFFF) score_q <= score_q + 16'd1;
                end else begin
                    pt_cnt <= pt_cnt - 1'b1;
                end
                if (st_cnt == '0) begin
                    st_cnt <= ST_LOAD;
                    if (speed_q < SPD_MAX) speed_q <= speed_q + 4'd1;
                end else begin
                    st_cnt <= st_cnt - 1'b1;
                end
            end else if ((state == S_OVER) & tick & (ho_cnt != '0)) begin
                ho_cnt <= ho_cnt - 1'b1;
            end
        end
    end

    assign gif.game_status = status_c;
    assign gif.game_over   = over_c;
    assign gif.speed       = speed_q;
    assign gif.score       = score_q;
    assign gif.high_score  = high_q;
    assign gif.frame_tick  = ftick_q;

endmodule

// File: tb/tb_game_ctrl.sv
// Directed bench for game_ctrl with a frame-count based reference model.
module tb_game_ctrl;
    localparam int START = 1;
    localparam int MAXS  = 3;
    localparam int STEP  = 4;
    localparam int POINT = 2;
    localparam int HOLD  = 3;

    logic CLK = 1'b0;
    logic rst = 1'b1;
    always #5 CLK = ~CLK;

    game_ctrl_if gif();

    game_ctrl #(
        .START_SPEED(START), .MAX_SPEED(MAXS), .FRAMES_PER_STEP(STEP),
        .FRAMES_PER_POINT(POINT), .OVER_HOLDOFF(HOLD)
    ) dut (
        .CLK(CLK),
        .rst(rst),
        .gif(gif)
    );

    int n_checks = 0;
    int n_errors = 0;
    bit chk_en = 1'b1;
    int ftick_cnt = 0;

    task automatic check(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: mode 0 idle, 1 run, 2 over. Score and speed are derived from
    // the number of clean frames survived in the current run.
    int m_mode = 0;
    int m_frames = 0;
    int m_high = 0;
    int m_over_ticks = 0;
    bit m_hit = 0, m_btn_q = 0, m_fresh_q = 0, m_ftick = 0;

    function automatic int m_score();
        int s;
        s = m_frames / POINT;
        return (s > 65535) ? 65535 : s;
    endfunction

    function automatic int m_speed();
        int s;
        s = START + m_frames / STEP;
        return (s > MAXS) ? MAXS : s;
    endfunction

    always @(posedge CLK) begin
        bit press, tick, start, die, hit_next;
        if (rst) begin
            m_mode = 0; m_frames = 0; m_high = 0; m_over_ticks = 0;
            m_hit = 0; m_btn_q = 0; m_fresh_q = 0; m_ftick = 0;
        end else begin
            press = gif.button_jump && !m_btn_q;
            tick  = gif.fresh && !m_fresh_q;
            start = press && (m_mode == 0 || (m_mode == 2 && m_over_ticks >= HOLD));
            die   = (m_mode == 1) && tick && (m_hit || gif.collision);
            if (tick || start) hit_next = 0;
            else if (m_mode == 1 && gif.collision) hit_next = 1;
            else hit_next = m_hit;

            if (start) begin
                m_mode = 1; m_frames = 0;
            end else if (die) begin
                m_mode = 2;
                if (m_score() > m_high) m_high = m_score();
                m_over_ticks = 0;
            end else if (m_mode == 1 && tick) begin
                m_frames++;
            end else if (m_mode == 2 && tick && m_over_ticks < HOLD) begin
                m_over_ticks++;
            end
            m_hit = hit_next;
            m_btn_q = gif.button_jump;
            m_fresh_q = gif.fresh;
            m_ftick = tick;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("game_status", int'(gif.game_status), int'(m_mode == 1));
            check("game_over",   int'(gif.game_over),   int'(m_mode == 2));
            check("speed",       int'(gif.speed),       m_speed());
            check("score",       int'(gif.score),       m_score());
            check("high_score",  int'(gif.high_score),  m_high);
            check("frame_tick",  int'(gif.frame_tick),  int'(m_ftick));
            if (gif.frame_tick) ftick_cnt++;
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge CLK);
    endtask

    task automatic frame();
        gif.fresh = 1'b1; cyc(2);
        gif.fresh = 1'b0; cyc(2);
    endtask

    task automatic frames(input int n);
        for (int i = 0; i < n; i++) frame();
    endtask

    task automatic press();
        gif.button_jump = 1'b1; cyc(2);
        gif.button_jump = 1'b0; cyc(1);
    endtask

    task automatic hit_pulse();
        gif.collision = 1'b1; cyc(1);
        gif.collision = 1'b0; cyc(1);
    endtask

    initial begin
        int ft0;
        gif.fresh = 1'b0;
        gif.button_jump = 1'b0;
        gif.collision = 1'b0;
        rst = 1'b1;
        cyc(3);
        check("rst_status", int'(gif.game_status), 0);
        check("rst_speed", int'(gif.speed), 1);
        check("rst_score", int'(gif.score), 0);
        check("rst_ftick", int'(gif.frame_tick), 0);
        rst = 1'b0;
        cyc(2);

        // Press from IDLE: RUN on the edge that samples the press.
        gif.button_jump = 1'b1;
        cyc(1);
        check("start_status", int'(gif.game_status), 1);
        cyc(1);
        gif.button_jump = 1'b0;
        cyc(1);
        check("start_speed", int'(gif.speed), 1);
        check("start_score", int'(gif.score), 0);

        // 20 clean frames: score 10, speed ramps to the ceiling.
        ft0 = ftick_cnt;
        frames(3);
        check("speed_before_step", int'(gif.speed), 1);
        frames(1);
        check("speed_step1", int'(gif.speed), 2);
        frames(16);
        check("run20_score", int'(gif.score), 10);
        check("run20_speed", int'(gif.speed), 3);
        check("run20_ftick_count", ftick_cnt - ft0, 20);

        // Mid-frame collision pulse kills on the next frame.
        hit_pulse();
        check("hit_not_yet_over", int'(gif.game_over), 0);
        frame();
        check("over_flag", int'(gif.game_over), 1);
        check("over_score", int'(gif.score), 10);
        check("over_high", int'(gif.high_score), 10);

        // Holdoff: press after one frame is ignored.
        frame();
        press();
        check("holdoff_ignore", int'(gif.game_over), 1);
        frames(2);
        press();
        check("restart_status", int'(gif.game_status), 1);
        check("restart_score", int'(gif.score), 0);
        check("restart_speed", int'(gif.speed), 1);
        check("restart_high", int'(gif.high_score), 10);

        // Lower second score leaves the high score alone.
        frames(4);
        hit_pulse();
        frame();
        check("run2_score", int'(gif.score), 2);
        check("run2_high", int'(gif.high_score), 10);

        // Held button: one restart only.
        frames(3);
        gif.button_jump = 1'b1;
        cyc(2);
        check("held_restart", int'(gif.game_status), 1);
        hit_pulse();
        frame();
        frames(4);
        check("held_no_second", int'(gif.game_over), 1);
        gif.button_jump = 1'b0;
        cyc(1);

        // Reset mid-run with score 7.
        press();
        frames(14);
        check("pre_rst_score", int'(gif.score), 7);
        rst = 1'b1;
        cyc(1);
        rst = 1'b0;
        check("midrst_status", int'(gif.game_status), 0);
        check("midrst_high", int'(gif.high_score), 0);
        check("midrst_score", int'(gif.score), 0);
        check("midrst_speed", int'(gif.speed), 1);
        cyc(2);

        // Press coinciding with a tick from IDLE: that tick is not counted.
        gif.button_jump = 1'b1;
        gif.fresh = 1'b1;
        cyc(2);
        gif.button_jump = 1'b0;
        gif.fresh = 1'b0;
        cyc(2);
        check("cotick_status", int'(gif.game_status), 1);
        frame();
        check("cotick_score1", int'(gif.score), 0);
        frame();
        check("cotick_score2", int'(gif.score), 1);

        chk_en = 1'b0;
        cyc(1);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
